uart_rx_ctrl: RTL

Receive-side sequencer for the UART RX path. It detects the start bit, times the mid-bit sample points for the data and stop bits using the oversample tick, and assembles the data bits LSB-first. It checks the stop bit and presents each completed word on a valid/ready handshake toward the host or FIFO. It sits between the raw RX pin and the consumer, replacing ad-hoc free-running timers with a single explicit FSM.

---
 rtl/uart_rx_ctrl_if.sv | 12 +
 rtl/uart_rx_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Receive-word handshake between the UART RX sequencer and its consumer.
// A word is transferred on every clock edge where o_valid and i_ready are both high.
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, mid-bit sampling on the oversample tick,
// LSB-first assembly, stop-bit check and a single-entry valid/ready output stage.
module uart_rx_ctrl #(
    parameter int OSR       = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_rx,
    uart_rx_ctrl_if.master        host,
    output logic                  o_frame_err,
    output logic                  o_overrun,
    output logic                  o_busy,
    output logic [2:0]            o_dbg_state
);
    localparam int TW = $clog2(OSR);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OSR - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               state, state_nx;
    logic [TW-1:0]        tick, tick_nx;
    logic [BW-1:0]        bit_cnt, bit_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 rx_meta, rx_s;
    logic                 word_done, stop_low;

    // Two-flop synchronizer, preset to the idle-high line level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            tick    <= tick_nx;
            bit_cnt <= bit_nx;
            shreg   <= shreg_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tick_nx   = tick;
        bit_nx    = bit_cnt;
        shreg_nx  = shreg;
        word_done = 1'b0;
        stop_low  = 1'b0;
        if (i_en) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_nx = S_START;
                        tick_nx  = '0;
                    end
                end
                S_START: begin
                    if (tick == TICK_MID) begin
                        tick_nx  = '0;
                        bit_nx   = '0;
                        state_nx = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_nx = tick + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick == TICK_END) begin
                        tick_nx  = '0;
                        shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
                        bit_nx   = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) state_nx = S_STOP;
                    end else begin
                        tick_nx = tick + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick == TICK_END) begin
                        tick_nx   = '0;
                        word_done = 1'b1;
                        stop_low  = !rx_s;
                        // A low stop bit parks in BREAK so a held-low line cannot retrigger.
                        state_nx  = rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        tick_nx = tick + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // A new word always lands; it counts as an overrun only if the held one was not taken this cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            host.o_data  <= '0;
            host.o_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_frame_err <= stop_low;
            if (word_done) begin
                host.o_data  <= shreg;
                host.o_valid <= 1'b1;
                o_overrun    <= host.o_valid & ~host.i_ready;
            end else begin
                o_overrun <= 1'b0;
                if (host.o_valid && host.i_ready) host.o_valid <= 1'b0;
            end
        end
    end

    assign o_busy      = (state != S_IDLE);
    assign o_dbg_state = state;
endmodule
